// File: rtl/spi_seq_pkg.sv
// Shared types and defaults for the SPI byte sequencer.
package spi_seq_pkg;

  typedef logic [7:0] spi_byte_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    XFER,
    CAPTURE,
    GAP
  } seq_state_e;

  localparam int unsigned DefaultDepth      = 8;
  localparam int unsigned DefaultXferCycles = 16;
  localparam int unsigned DefaultGapCycles  = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous TX byte FIFO with registered occupancy and ready.
module spi_seq_fifo
  import spi_seq_pkg::*;
#(
  parameter int unsigned DEPTH  = DefaultDepth,
  localparam int unsigned PtrW   = $clog2(DEPTH),
  localparam int unsigned CountW = PtrW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  spi_byte_t         wdata,
  input  logic              pop,
  output spi_byte_t         rdata,
  output logic [CountW-1:0] count,
  output logic              full,
  output logic              empty,
  output logic              ready
);

  spi_byte_t         mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q, count_d;
  logic              ready_q;
  logic              push_ok, pop_ok;

  assign full  = (count_q == CountW'(DEPTH));
  assign empty = (count_q == '0);

  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CountW'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CountW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      ready_q <= (count_d != CountW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign ready = ready_q;

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Feeds buffered bytes to SPI_intf one at a time, holding en for a fixed window.
// Define SPI_SEQ_RX_EN to add the CAPTURE state and rx_data/rx_valid capture.
module spi_xfer_sequencer
  import spi_seq_pkg::*;
#(
  parameter int unsigned DEPTH       = DefaultDepth,
  parameter int unsigned XFER_CYCLES = DefaultXferCycles,
  parameter int unsigned GAP_CYCLES  = DefaultGapCycles,
  localparam int unsigned CountW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              spi_en,
  output logic [7:0]        spi_data,
  input  logic [7:0]        spi_rdata,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic [CountW-1:0] count,
  output logic              overflow
);

  localparam int unsigned CntW = $clog2(max3(XFER_CYCLES, GAP_CYCLES, 2));
  localparam logic [CntW-1:0] XferLast = CntW'(XFER_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  seq_state_e      state_q, after_state;
  logic [CntW-1:0] cnt_q;
  logic            spi_en_q;
  spi_byte_t       spi_data_q;
  logic            overflow_q;

  spi_byte_t       fifo_rdata;
  logic            fifo_pop, fifo_full, fifo_empty;

  assign fifo_pop = (state_q == LOAD);

  spi_seq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_valid),
    .wdata (tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty),
    .ready (tx_ready)
  );

  // Where the FSM goes once a byte's enable window (and capture) is done.
  always_comb begin
    after_state = fifo_empty ? IDLE : LOAD;
    if (GAP_CYCLES != 0) after_state = GAP;
  end

`ifdef SPI_SEQ_RX_EN
  spi_byte_t rx_data_q;
  logic      rx_valid_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      spi_en_q   <= 1'b0;
      spi_data_q <= '0;
`ifdef SPI_SEQ_RX_EN
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
`endif
    end else begin
`ifdef SPI_SEQ_RX_EN
      rx_valid_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) state_q <= LOAD;
        end
        LOAD: begin
          spi_data_q <= fifo_rdata;
          spi_en_q   <= 1'b1;
          cnt_q      <= XferLast;
          state_q    <= XFER;
        end
        XFER: begin
          if (cnt_q == '0) begin
            spi_en_q <= 1'b0;
`ifdef SPI_SEQ_RX_EN
            state_q  <= CAPTURE;
`else
            state_q  <= after_state;
            cnt_q    <= GapLast;
`endif
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
`ifdef SPI_SEQ_RX_EN
        CAPTURE: begin
          rx_data_q  <= spi_rdata;
          rx_valid_q <= 1'b1;
          state_q    <= after_state;
          cnt_q      <= GapLast;
        end
`endif
        GAP: begin
          if (cnt_q == '0) begin
            state_q <= fifo_empty ? IDLE : LOAD;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (tx_valid && fifo_full && !fifo_pop) begin
      overflow_q <= 1'b1;
    end
  end

`ifdef SPI_SEQ_RX_EN
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^spi_rdata;
  assign rx_data  = '0;
  assign rx_valid = 1'b0;
`endif

  assign spi_en   = spi_en_q;
  assign spi_data = spi_data_q;
  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Scoreboard bench for spi_xfer_sequencer; expectations follow SPI_SEQ_RX_EN.
module tb_spi_xfer_sequencer;

  localparam int unsigned Depth = 8;
  localparam int unsigned Xfer  = 16;
  localparam int unsigned Gap   = 2;
`ifdef SPI_SEQ_RX_EN
  localparam int unsigned RxCyc = 1;
`else
  localparam int unsigned RxCyc = 0;
`endif
  // Byte-to-byte period and enable low time when bytes are queued back to back.
  localparam int unsigned Period = Xfer + RxCyc + Gap + 1;
  localparam int unsigned LowExp = RxCyc + Gap + 1;

  logic       clk, rst_n;
  logic [7:0] tx_data, spi_data, spi_rdata, rx_data;
  logic       tx_valid, tx_ready, spi_en, rx_valid, busy, overflow;
  logic [3:0] count;

  spi_xfer_sequencer #(
    .DEPTH       (Depth),
    .XFER_CYCLES (Xfer),
    .GAP_CYCLES  (Gap)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .spi_en    (spi_en),
    .spi_data  (spi_data),
    .spi_rdata (spi_rdata),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: checks each presented byte, enable width and captured rx bytes.
  logic       en_prev = 1'b0;
  int         width   = 0;
  logic [7:0] cur     = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      en_prev = 1'b0;
      width   = 0;
    end else begin
      if (spi_en && !en_prev) begin
        if (tx_q.size() == 0) chk("unexpected_xfer", 1, 0);
        else begin
          cur = tx_q.pop_front();
          chk("spi_data_order", spi_data, cur);
        end
        width = 1;
      end else if (spi_en) begin
        width++;
        chk("spi_data_stable", spi_data, cur);
      end else if (en_prev) begin
        chk("spi_en_width", width, Xfer);
      end
      if (rx_valid) begin
        if (rx_q.size() == 0) chk("unexpected_rx_valid", 1, 0);
        else chk("rx_data", rx_data, rx_q.pop_front());
      end
      en_prev = spi_en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit accepted, input logic [7:0] rx_exp);
    tx_data  = d;
    tx_valid = 1'b1;
    if (accepted) begin
      tx_q.push_back(d);
      if (RxCyc != 0) rx_q.push_back(rx_exp);
    end
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_en(input logic lvl, output int n);
    n = 0;
    while (spi_en !== lvl && n < 400) begin
      tick();
      n++;
    end
    if (spi_en !== lvl) chk("wait_spi_en_timeout", 0, 1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) chk("wait_idle_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    spi_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_spi_en", spi_en, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_spi_data", spi_data, 0);
    chk("rst_rx_data", rx_data, 0);
    rst_n = 1'b1;
    tick();

    // Single byte: enable rises two edges after the push.
    spi_rdata = 8'h3C;
    push(8'hB5, 1, 8'h3C);
    chk("single_count", count, 1);
    chk("single_idle_k", busy, 0);
    tick();
    chk("single_load_busy", busy, 1);
    chk("single_load_en", spi_en, 0);
    tick();
    chk("single_en_rise", spi_en, 1);
    chk("single_spi_data", spi_data, 8'hB5);
    wait_en(1'b0, n);
    chk("single_en_cycles", n, Xfer);
    tick();
    chk("single_rx_valid", rx_valid, RxCyc);
    if (RxCyc != 0) chk("single_rx_data", rx_data, 8'h3C);
    tick();
    chk("single_rx_valid_off", rx_valid, 0);
    wait_idle(n);

    // Burst of eight bytes pushed back to back.
    spi_rdata = 8'h5A;
    for (int i = 1; i <= 8; i++) push(8'(i), 1, 8'h5A);
    wait_en(1'b0, n);
    for (int i = 0; i < 7; i++) begin
      wait_en(1'b1, n);
      chk("burst_en_low", n, LowExp);
      wait_en(1'b0, n);
      chk("burst_en_high", n, Xfer);
    end
    wait_idle(n);
    chk("burst_busy_tail", n, Gap + RxCyc);

    // Overflow: fill to eight, drop one, then push into a full FIFO on a pop edge.
    spi_rdata = 8'h77;
    for (int i = 0; i < 9; i++) push(8'h10 + 8'(i), 1, 8'h77);
    chk("ovf_count_full", count, 8);
    chk("ovf_ready_low", tx_ready, 0);
    chk("ovf_not_yet", overflow, 0);
    push(8'hEE, 0, 8'h00);
    chk("ovf_set", overflow, 1);
    chk("ovf_count_kept", count, 8);
    repeat (Period - 8) tick();
    chk("full_before_pop", count, 8);
    push(8'h19, 1, 8'h77);
    chk("pushpop_count", count, 8);
    chk("pushpop_ready", tx_ready, 0);
    chk("pushpop_en", spi_en, 1);
    chk("ovf_sticky", overflow, 1);
    wait_idle(n);
    chk("drain_count", count, 0);
    chk("drain_ready", tx_ready, 1);
    chk("drain_ovf_sticky", overflow, 1);

    // Reset in the fifth XFER cycle.
    spi_rdata = 8'h99;
    push(8'hA7, 1, 8'h99);
    tick();
    tick();
    chk("rst_mid_en_high", spi_en, 1);
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    rx_q.delete();
    #1;
    chk("rst_mid_en", spi_en, 0);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ovf", overflow, 0);
    chk("rst_mid_ready", tx_ready, 1);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (30) tick();
    chk("rst_no_rx_valid", rx_valid, 0);
    chk("rst_idle", busy, 0);

    // Resume after reset.
    spi_rdata = 8'h24;
    push(8'h42, 1, 8'h24);
    tick();
    tick();
    chk("resume_en", spi_en, 1);
    wait_idle(n);
    chk("resume_spi_data_hold", spi_data, 8'h42);
    chk("tx_queue_drained", tx_q.size(), 0);
    chk("rx_queue_drained", rx_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
